tlk2711_rd_cmd_gen: RTL

Upstream command scheduler for the TLK2711 DMA read (MM2S) path. It takes one software-configured frame (base address and total byte length) and splits it into per-packet read commands of at most i_pkt_len bytes. Commands are issued on the DMA read command req/ack interface. Outstanding commands are credit-limited and retired by the DMA read-last pulses; one done pulse is reported per frame.

---
 rtl/tlk2711_pkg.sv | 11 +
 rtl/tlk2711_credit_cnt.sv | 24 ++
 rtl/tlk2711_rd_cmd_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/tlk2711_pkg.sv
// tlk2711_pkg: shared types, command-field widths and helpers for the TLK2711 DMA read path
package tlk2711_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DLEN_WIDTH = 16;
    localparam int TLEN_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    function automatic logic [TLEN_WIDTH-1:0] min_len(input logic [TLEN_WIDTH-1:0] pkt,
                                                      input logic [TLEN_WIDTH-1:0] remaining);
        return (pkt < remaining) ? pkt : remaining;
    endfunction
endpackage

// File: rtl/tlk2711_credit_cnt.sv
// tlk2711_credit_cnt: outstanding-command counter with saturation and underflow detect
// Ports: inc (command accepted), dec (command retired); full/empty describe the count
// after this cycle's update, err flags a retire with nothing outstanding (count holds at 0).
module tlk2711_credit_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty,
    output logic err
);
    logic [W-1:0] cnt_q, cnt_n;
    always_comb begin
        err   = dec && !inc && cnt_q == '0;
        cnt_n = err ? cnt_q : cnt_q + W'(inc) - W'(dec);
        full  = cnt_n == W'(MAX);
        empty = cnt_n == '0;
    end
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_n;
endmodule

// File: rtl/tlk2711_rd_cmd_gen.sv
// tlk2711_rd_cmd_gen: splits one configured frame into credit-limited DMA read commands
// Ports: i_start/i_base_addr/i_total_len/i_pkt_len configure a frame; o_rd_cmd_data/o_rd_cmd_req/
// i_rd_cmd_ack issue {addr, len} commands; i_dma_rd_last retires one command; o_busy/o_done/o_err
// report frame status; o_cmd_cnt counts commands issued in the current or last frame.
module tlk2711_rd_cmd_gen
    import tlk2711_pkg::*;
#(
    parameter int ADDR_WIDTH = tlk2711_pkg::ADDR_WIDTH,
    parameter int DLEN_WIDTH = tlk2711_pkg::DLEN_WIDTH,
    parameter int TLEN_WIDTH = tlk2711_pkg::TLEN_WIDTH,
    parameter int MAX_OUTST  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH-1:0]            i_base_addr,
    input  logic [TLEN_WIDTH-1:0]            i_total_len,
    input  logic [DLEN_WIDTH-1:0]            i_pkt_len,
    output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_rd_cmd_data,
    output logic                             o_rd_cmd_req,
    input  logic                             i_rd_cmd_ack,
    input  logic                             i_dma_rd_last,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err,
    output logic [15:0]                      o_cmd_cnt
);
    state_t                  state_q, state_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic [TLEN_WIDTH-1:0]   rem_q, rem_n, len;
    logic [DLEN_WIDTH-1:0]   pkt_q, pkt_n;
    logic [15:0]             cnt_q, cnt_n;
    logic                    busy_q, busy_n, done_q, done_n, err_q, err_n, req_q, req_n;
    logic                    acc, full, empty, unf, illegal;

    tlk2711_credit_cnt #(.MAX(MAX_OUTST)) u_credit (
        .clk  (clk),
        .rst  (rst),
        .inc  (acc),
        .dec  (i_dma_rd_last),
        .full (full),
        .empty(empty),
        .err  (unf)
    );

    // address and remaining only move on acceptance, so the command word is stable while waiting for ack
    assign len           = min_len(TLEN_WIDTH'(pkt_q), rem_q);
    assign o_rd_cmd_data = {addr_q, len[DLEN_WIDTH-1:0]};
    assign acc           = req_q && i_rd_cmd_ack;
    assign illegal       = i_total_len == '0 || i_pkt_len == '0 || i_base_addr[2:0] != 3'd0;

    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        rem_n   = rem_q;
        pkt_n   = pkt_q;
        cnt_n   = cnt_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        err_n   = unf;
        case (state_q)
            IDLE: if (i_start) begin
                addr_n  = i_base_addr;
                rem_n   = i_total_len;
                pkt_n   = i_pkt_len;
                err_n   = err_n || illegal;
                state_n = illegal ? IDLE : ISSUE;
                busy_n  = !illegal;
                cnt_n   = illegal ? cnt_q : 16'd0;
            end
            ISSUE: if (acc) begin
                addr_n  = addr_q + ADDR_WIDTH'(len[DLEN_WIDTH-1:0]);
                rem_n   = rem_q - len;
                cnt_n   = cnt_q + 16'd1;
                state_n = rem_n == '0 ? DRAIN : ISSUE;
            end
            DRAIN: if (empty) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // full/empty already include this cycle's accept and retire
        req_n = state_n == ISSUE && rem_n != '0 && !full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pkt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            rem_q   <= rem_n;
            pkt_q   <= pkt_n;
            cnt_q   <= cnt_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
            req_q   <= req_n;
        end
    end

    assign o_rd_cmd_req = req_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_cmd_cnt    = cnt_q;
endmodule
